branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: tagged entries with 2-bit counters and stored targets.
// Lookup is purely combinational; updates land on the clock edge and are gated by rdy.
module branch_predictor #(
  parameter int IDX_BITS = 7,
  parameter int TAG_BITS = 32 - IDX_BITS - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        jump_predict,
  output logic [31:0] predict_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic                valid_q [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [1:0]          ctr_q   [ENTRIES];
  logic [31:0]         tgt_q   [ENTRIES];

  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic                up_pred;
  logic [31:0]         up_pred_tgt;
  logic                up_mis;
  logic                up_en;
  logic [1:0]          ctr_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup sees only registered contents, so a same-cycle write is invisible.
  always_comb begin
    lk_idx         = pc[IDX_BITS+1:2];
    lk_tag         = pc[31:IDX_BITS+2];
    lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    jump_predict   = lk_hit && ctr_q[lk_idx][1];
    predict_target = jump_predict ? tgt_q[lk_idx] : 32'd0;
  end

  always_comb begin
    up_idx      = upd_pc[IDX_BITS+1:2];
    up_tag      = upd_pc[31:IDX_BITS+2];
    up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred     = up_hit && ctr_q[up_idx][1];
    up_pred_tgt = up_pred ? tgt_q[up_idx] : 32'd0;
    up_mis      = (up_pred != upd_taken) || (upd_taken && (up_pred_tgt != upd_target));
    up_en       = upd_valid && rdy;

    ctr_d = ctr_q[up_idx];
    if (!upd_is_branch) begin
      ctr_d = 2'b11;
    end else if (up_hit) begin
      if (upd_taken) begin
        if (ctr_q[up_idx] != 2'b11) ctr_d = ctr_q[up_idx] + 2'd1;
      end else begin
        if (ctr_q[up_idx] != 2'b00) ctr_d = ctr_q[up_idx] - 2'd1;
      end
    end else begin
      ctr_d = upd_taken ? 2'b10 : 2'b01;
    end

    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (up_en) begin
      stat_lookups_d = stat_lookups_q + 32'd1;
      if (up_mis) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= 32'd0;
      end
      stat_lookups_q     <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else if (up_en) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= ctr_d;
      if (upd_taken) tgt_q[up_idx] <= upd_target;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed predictions, counters and statistics.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] pc;
  logic        jump_predict;
  logic [31:0] predict_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .pc               (pc),
    .jump_predict     (jump_predict),
    .predict_target   (predict_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_branch    (upd_is_branch),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] a, input logic br, input logic tk, input logic [31:0] t);
    upd_valid     = 1'b1;
    upd_pc        = a;
    upd_is_branch = br;
    upd_taken     = tk;
    upd_target    = t;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic jp, input logic [31:0] t);
    pc = a;
    #1;
    chk({tag, ".jp"}, {31'd0, jump_predict}, {31'd0, jp});
    chk({tag, ".tgt"}, predict_target, t);
  endtask

  task automatic stats(input string tag, input logic [31:0] l, input logic [31:0] m);
    chk({tag, ".lookups"}, stat_lookups, l);
    chk({tag, ".mispred"}, stat_mispredicts, m);
  endtask

  // Index of 0x100 and 0x300 is 0x40; index of 0x40 is 0x10.
  initial begin
    rst = 1'b1; rdy = 1'b1; pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_is_branch = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h80;
    step();
    step();
    rst = 1'b0; upd_valid = 1'b0;
    look("reset", 32'h100, 1'b0, 32'h0);
    stats("reset", 0, 0);
    chk("reset.ctr", {30'd0, dut.ctr_q[7'h40]}, 32'd1);

    upd(32'h100, 1'b1, 1'b1, 32'h80);
    look("install", 32'h100, 1'b1, 32'h80);
    stats("install", 1, 1);
    chk("install.ctr", {30'd0, dut.ctr_q[7'h40]}, 32'd2);

    upd(32'h100, 1'b1, 1'b0, 32'h0);
    chk("nt1.ctr", {30'd0, dut.ctr_q[7'h40]}, 32'd1);
    stats("nt1", 2, 2);
    upd(32'h100, 1'b1, 1'b0, 32'h0);
    chk("nt2.ctr", {30'd0, dut.ctr_q[7'h40]}, 32'd0);
    stats("nt2", 3, 2);
    look("nt2", 32'h100, 1'b0, 32'h0);
    chk("nt2.kept_tgt", dut.tgt_q[7'h40], 32'h80);

    upd(32'h100, 1'b1, 1'b1, 32'h80);
    upd(32'h100, 1'b1, 1'b1, 32'h80);
    look("retrain", 32'h100, 1'b1, 32'h80);
    stats("retrain", 5, 4);
    look("alias_miss", 32'h300, 1'b0, 32'h0);
    upd(32'h300, 1'b1, 1'b1, 32'h400);
    look("alias_new", 32'h300, 1'b1, 32'h400);
    look("alias_old", 32'h100, 1'b0, 32'h0);
    stats("alias", 6, 5);

    pc = 32'h300;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_is_branch = 1'b1;
    upd_taken = 1'b0; upd_target = 32'h0;
    #1;
    chk("same.old_jp", {31'd0, jump_predict}, 32'd1);
    chk("same.old_tgt", predict_target, 32'h400);
    step();
    upd_valid = 1'b0;
    look("same.next", 32'h300, 1'b0, 32'h0);
    stats("same", 7, 6);

    rdy = 1'b0;
    upd(32'h300, 1'b1, 1'b1, 32'h999);
    upd(32'h40, 1'b0, 1'b1, 32'h200);
    rdy = 1'b1;
    stats("frozen", 7, 6);
    chk("frozen.ctr", {30'd0, dut.ctr_q[7'h40]}, 32'd1);
    look("frozen.300", 32'h300, 1'b0, 32'h0);
    look("frozen.40", 32'h40, 1'b0, 32'h0);

    upd(32'h40, 1'b0, 1'b1, 32'h200);
    look("jal", 32'h40, 1'b1, 32'h200);
    chk("jal.ctr", {30'd0, dut.ctr_q[7'h10]}, 32'd3);
    stats("jal", 8, 7);

    upd(32'h40, 1'b1, 1'b1, 32'h200);
    chk("sat.ctr", {30'd0, dut.ctr_q[7'h10]}, 32'd3);
    stats("sat", 9, 7);
    upd(32'h40, 1'b1, 1'b1, 32'h204);
    look("tgt_mis", 32'h40, 1'b1, 32'h204);
    stats("tgt_mis", 10, 8);

    rst = 1'b1; rdy = 1'b0;
    upd(32'h80, 1'b0, 1'b1, 32'h500);
    rst = 1'b0; rdy = 1'b1;
    look("rst2.40", 32'h40, 1'b0, 32'h0);
    look("rst2.80", 32'h80, 1'b0, 32'h0);
    stats("rst2", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
